// File: rtl/imem_dump.sv
// Instruction-memory read-back engine: on start it owns the memory port, holds the CPU,
// and streams a block of consecutive words out over a valid/ready interface.
module imem_dump #(
    parameter int DEPTH = 256,
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [IDX_W:0]   num_words,
    output logic             busy,
    output logic             done,
    output logic             cpu_hold,
    output logic             mem_rd_en,
    output logic [31:0]      mem_addr,
    input  logic [31:0]      mem_rdata,
    output logic [31:0]      dout,
    output logic [IDX_W-1:0] dout_idx,
    output logic             dout_valid,
    input  logic             dout_ready
);

    localparam logic [IDX_W:0] MAX_CNT = (IDX_W+1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, READ, WAIT, SEND, DONE} state_t;

    state_t           state;
    logic [IDX_W-1:0] base_widx;
    logic [IDX_W:0]   cnt;
    logic [IDX_W:0]   idx;

    logic [IDX_W:0]   req_cnt;
    logic [IDX_W-1:0] req_widx;
    logic [IDX_W:0]   idx_inc;
    logic [IDX_W-1:0] next_widx;

    // Word index arithmetic is IDX_W wide so the address wraps modulo DEPTH for free.
    assign req_cnt   = (num_words > MAX_CNT) ? MAX_CNT : num_words;
    assign req_widx  = base_addr[IDX_W+1:2];
    assign idx_inc   = idx + (IDX_W+1)'(1);
    assign next_widx = base_widx + idx_inc[IDX_W-1:0];
    assign cpu_hold  = busy;

    function automatic logic [31:0] word_addr(input logic [IDX_W-1:0] w);
        return {{(30-IDX_W){1'b0}}, w, 2'b00};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            base_widx  <= '0;
            cnt        <= '0;
            idx        <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            mem_rd_en  <= 1'b0;
            mem_addr   <= '0;
            dout       <= '0;
            dout_idx   <= '0;
            dout_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        base_widx <= req_widx;
                        cnt       <= req_cnt;
                        idx       <= '0;
                        busy      <= 1'b1;
                        if (req_cnt != '0) begin
                            state     <= READ;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= word_addr(req_widx);
                        end else begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                READ: begin
                    mem_rd_en <= 1'b0;
                    mem_addr  <= '0;
                    state     <= WAIT;
                end
                WAIT: begin
                    dout       <= mem_rdata;
                    dout_idx   <= idx[IDX_W-1:0];
                    dout_valid <= 1'b1;
                    state      <= SEND;
                end
                SEND: begin
                    // Output words are held until accepted; the next read waits for the handshake.
                    if (dout_ready) begin
                        dout_valid <= 1'b0;
                        idx        <= idx_inc;
                        if (idx_inc == cnt) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state     <= READ;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= word_addr(next_widx);
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_dump.sv
// Bench for imem_dump: a memory image plus a per-transaction model of the expected
// word stream, checked every cycle, with directed timing/boundary scenarios and random traffic.
module tb_imem_dump;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [8:0]  num_words = '0;
    logic        busy, done, cpu_hold, mem_rd_en, dout_valid;
    logic [31:0] mem_addr, dout;
    logic [31:0] mem_rdata = '0;
    logic [7:0]  dout_idx;
    logic        dout_ready = 1'b0;

    imem_dump #(.DEPTH(256), .IDX_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_words(num_words),
        .busy(busy), .done(done), .cpu_hold(cpu_hold), .mem_rd_en(mem_rd_en),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .dout(dout), .dout_idx(dout_idx),
        .dout_valid(dout_valid), .dout_ready(dout_ready)
    );

    always #5 clk = ~clk;

    logic [31:0] mem_img [256];
    always @(posedge clk) if (mem_rd_en) mem_rdata <= mem_img[mem_addr[9:2]];

    int tests = 0, fails = 0;
    int cyc = 0;
    // transaction model
    int txn_id = 0, seen_id = -1, txn_base = 0, txn_cnt = 0;
    int acc_cnt, rd_cnt, first_rd, first_vld, done_cyc, done_cnt = 0, stall_cyc;
    bit done_seen, stall_prev;
    logic [31:0] prev_dout;
    logic [7:0]  prev_idx;
    logic [31:0] got_q[$];
    logic [31:0] rd_addr_q[$];
    // ready generation
    int ready_mode = 0, stall_left = 0;
    bit ready_val = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic compare();
        if (rst) begin
            stall_prev = 1'b0;
            return;
        end
        if (seen_id != txn_id) begin
            seen_id = txn_id; acc_cnt = 0; rd_cnt = 0; first_rd = -1; first_vld = -1;
            done_cyc = -1; stall_cyc = 0; done_seen = 1'b0; stall_prev = 1'b0;
            got_q.delete(); rd_addr_q.delete();
        end
        chk("hold_eq_busy", cpu_hold, busy);
        if (!mem_rd_en) chk("addr_idle", mem_addr, 0);
        else begin
            chk("rd_addr", mem_addr, ((txn_base + rd_cnt) % 256) * 4);
            chk("rd_once", rd_cnt, acc_cnt);
            rd_addr_q.push_back(mem_addr);
            if (first_rd < 0) first_rd = cyc;
            rd_cnt++;
        end
        if (stall_prev) begin
            chk("stall_valid", dout_valid, 1);
            chk("stall_data", dout, prev_dout);
            chk("stall_idx", dout_idx, prev_idx);
        end
        if (dout_valid) begin
            if (first_vld < 0) first_vld = cyc;
            if (dout_ready) begin
                chk("dout", dout, mem_img[(txn_base + acc_cnt) % 256]);
                chk("dout_idx", dout_idx, acc_cnt);
                got_q.push_back(dout);
                acc_cnt++;
            end else stall_cyc++;
        end
        stall_prev = dout_valid && !dout_ready;
        prev_dout = dout;
        prev_idx = dout_idx;
        if (done) begin
            chk("done_count", acc_cnt, txn_cnt);
            chk("done_reads", rd_cnt, txn_cnt);
            chk("done_busy", busy, 1);
            done_seen = 1'b1; done_cyc = cyc; done_cnt++;
        end else if (done_seen) begin
            chk("post_done_idle", {busy, mem_rd_en, dout_valid}, 3'b000);
        end
        if (!busy) chk("valid_idle", dout_valid, 0);
    endtask

    task automatic tick();
        @(negedge clk);
        compare();
        @(posedge clk);
        cyc++;
        #1;
        case (ready_mode)
            0: dout_ready = ready_val;
            1: dout_ready = ($urandom_range(0, 3) != 0);
            default: begin
                if (dout_valid && dout_idx == 8'd1 && stall_left > 0) begin
                    dout_ready = 1'b0; stall_left--;
                end else dout_ready = 1'b1;
            end
        endcase
    endtask

    task automatic check_zero(input string nm);
        chk({nm, "_busy"}, busy, 0);
        chk({nm, "_done"}, done, 0);
        chk({nm, "_hold"}, cpu_hold, 0);
        chk({nm, "_rd_en"}, mem_rd_en, 0);
        chk({nm, "_addr"}, mem_addr, 0);
        chk({nm, "_dout"}, dout, 0);
        chk({nm, "_idx"}, dout_idx, 0);
        chk({nm, "_valid"}, dout_valid, 0);
    endtask

    // Issues one start and runs until the done pulse; optional stray starts while busy
    // and during the DONE cycle must be ignored.
    task automatic do_txn(input logic [31:0] base, input int num, input bit spurious, output int t0);
        int d0;
        bit to;
        start = 1'b1; base_addr = base; num_words = 9'(num);
        txn_base = int'(base[9:2]); txn_cnt = (num > 256) ? 256 : num;
        txn_id++; d0 = done_cnt; t0 = cyc;
        tick();
        start = spurious && (txn_cnt == 0);
        base_addr = $urandom;
        to = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            if (done_cnt != d0) begin to = 1'b0; break; end
            tick();
            start = spurious && ((dout_valid && dout_ready && int'(dout_idx) == txn_cnt - 1)
                                 || (i == 1 && busy));
        end
        if (to) chk("txn_timeout", 1, 0);
        start = 1'b0;
        tick();
    endtask

    initial begin
        int t0;
        logic [31:0] exp4 [4];
        for (int i = 0; i < 256; i++) mem_img[i] = $urandom;

        // reset
        for (int i = 0; i < 3; i++) tick();
        check_zero("rst");
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin tick(); check_zero("idle"); end

        // basic block with constant ready
        mem_img[0] = 11; mem_img[1] = 22; mem_img[2] = 33; mem_img[3] = 44;
        exp4 = '{32'd11, 32'd22, 32'd33, 32'd44};
        ready_mode = 0; ready_val = 1'b1;
        do_txn(32'h0, 4, 1'b0, t0);
        chk("first_rd_lat", first_rd, t0 + 1);
        chk("first_vld_lat", first_vld, t0 + 3);
        chk("done_time", done_cyc, t0 + 13);
        chk("basic_words", got_q.size(), 4);
        for (int i = 0; i < 4 && i < got_q.size(); i++) chk("basic_val", got_q[i], exp4[i]);

        // backpressure on word 1
        ready_mode = 2; stall_left = 5;
        do_txn(32'h0, 4, 1'b0, t0);
        chk("bp_stall_cycles", stall_cyc, 5);
        chk("bp_words", got_q.size(), 4);
        for (int i = 0; i < 4 && i < got_q.size(); i++) chk("bp_val", got_q[i], exp4[i]);

        // wrap at top of memory
        ready_mode = 0;
        do_txn(32'h3FD, 2, 1'b0, t0);
        chk("wrap_reads", rd_addr_q.size(), 2);
        if (rd_addr_q.size() == 2) begin
            chk("wrap_addr0", rd_addr_q[0], 32'h3FC);
            chk("wrap_addr1", rd_addr_q[1], 32'h000);
        end

        // zero length and clipped length
        do_txn(32'h40, 0, 1'b1, t0);
        chk("zero_done_time", done_cyc, t0 + 1);
        chk("zero_reads", rd_cnt, 0);
        chk("zero_valid", first_vld, -1);
        do_txn(32'h10, 300, 1'b0, t0);
        chk("clip_words", got_q.size(), 256);

        // reset while a word is waiting in SEND
        ready_val = 1'b0;
        start = 1'b1; base_addr = 32'h20; num_words = 9'd5;
        txn_base = 8; txn_cnt = 5; txn_id++;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10 && !dout_valid; i++) tick();
        chk("abort_in_send", dout_valid, 1);
        rst = 1'b1;
        tick();
        check_zero("abort");
        rst = 1'b0;
        ready_val = 1'b1;
        do_txn(32'h20, 5, 1'b0, t0);
        chk("restart_words", got_q.size(), 5);

        // random traffic
        ready_mode = 1;
        for (int n = 0; n < 25; n++) begin
            for (int i = 0; i < 256; i++) mem_img[i] = $urandom;
            do_txn($urandom, (n % 5 == 0) ? $urandom_range(0, 511) : $urandom_range(0, 40), 1'b1, t0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
